avlmm_master: RTL and testbench

AVLMM_MASTER -- requirements
Module: avlmm_master

---
 rtl/avlmm_master.sv | 175 +++++++++++++++++
 tb/tb_avlmm_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avlmm_master.sv
// -----------------------------------------------------------------------------
// avlmm_master
//   Single-outstanding Avalon-MM master. It takes one command, performs a single
//   read or write on the Avalon side and returns a one-cycle response. Every
//   Avalon-side output is registered.
//
//   Optional feature: define AVLMM_MASTER_TIMEOUT_EN to abort a transfer after
//   TIMEOUT_CYCLES consecutive waitrequest cycles. An aborted transfer returns a
//   response with rsp_error=1 and rsp_readdata=0. Without the macro the master
//   waits for waitrequest=0 indefinitely, and rsp_error is tied to 0.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
//   cmd_ready is high only in IDLE. cmd_valid in any other state is ignored and
//   is not queued. rsp_valid is a one-cycle strobe with no back-pressure. An
//   Avalon transfer completes on the rising edge where read/write is high and
//   waitrequest is low.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_address/
//   cmd_writedata                  command payload (1 = write)
//   rsp_valid/rsp_write/
//   rsp_readdata/rsp_error         response strobe and payload
//   read/write/address/writedata   Avalon-MM master outputs
//   readdata/waitrequest           Avalon-MM slave inputs
//   state_dbg                      current FSM state
//                                  (0 IDLE, 1 REQ, 2 RDWAIT, 3 RSP)
// -----------------------------------------------------------------------------
module avlmm_master #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [WORD_WIDTH-1:0] cmd_writedata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [WORD_WIDTH-1:0] rsp_readdata,
  output logic                  rsp_error,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] writedata,
  input  logic [WORD_WIDTH-1:0] readdata,
  input  logic                  waitrequest,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RSP    = 2'd3
  } state_t;

  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_t           state;
  logic             wr_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             timeout_hit;

  assign cmd_ready = (state == IDLE);
  assign state_dbg = state;

`ifdef AVLMM_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            rsp_error_q;

  // The abort fires on the edge that ends the TIMEOUT_CYCLES-th stalled cycle.
  // As a result the strobe is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (state == REQ) && waitrequest &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if ((state == REQ) && waitrequest && !timeout_hit)
        to_cnt <= to_cnt + TO_W'(1);
      else
        to_cnt <= '0;
      // rsp_error is decided when REQ is left. A read that leaves normally
      // clears it here, which is before its response appears.
      if ((state == REQ) && (!waitrequest || timeout_hit))
        rsp_error_q <= timeout_hit;
    end
  end

  assign rsp_error = rsp_error_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      read         <= 1'b0;
      write        <= 1'b0;
      address      <= '0;
      writedata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_write    <= 1'b0;
      rsp_readdata <= '0;
      lat_cnt      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wr_q      <= cmd_write;
            address   <= cmd_address;
            writedata <= cmd_writedata;
            read      <= !cmd_write;
            write     <= cmd_write;
            state     <= REQ;
          end
        end
        REQ: begin
          if (timeout_hit) begin
            read         <= 1'b0;
            write        <= 1'b0;
            rsp_readdata <= '0;
            rsp_valid    <= 1'b1;
            rsp_write    <= wr_q;
            state        <= RSP;
          end else if (!waitrequest) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (wr_q) begin
              rsp_valid <= 1'b1;
              rsp_write <= 1'b1;
              state     <= RSP;
            end else begin
              lat_cnt <= '0;
              state   <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          // lat_cnt counts the edges after the completing edge. Read data is
          // captured on the READ_LATENCY-th such edge.
          if (lat_cnt == LAT_LAST) begin
            rsp_readdata <= readdata;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            state        <= RSP;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        RSP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avlmm_master.sv
// -----------------------------------------------------------------------------
// tb_avlmm_master
//   Directed bench for avlmm_master (READ_LATENCY=1, TIMEOUT_CYCLES=8).
//   A small slave model holds a 16-word memory. It returns read data one cycle
//   after the completing edge and drives 0xBAD0BAD0 in all other cycles.
//   waitrequest is driven per command from a stall count.
// -----------------------------------------------------------------------------
module tb_avlmm_master;

  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [W-1:0]  cmd_writedata;
  logic          rsp_valid;
  logic          rsp_write;
  logic [W-1:0]  rsp_readdata;
  logic          rsp_error;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [W-1:0]  writedata;
  logic [W-1:0]  readdata;
  logic          waitrequest;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mem [16];

  avlmm_master #(
    .WORD_WIDTH    (W),
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_address  (cmd_address),
    .cmd_writedata(cmd_writedata),
    .rsp_valid    (rsp_valid),
    .rsp_write    (rsp_write),
    .rsp_readdata (rsp_readdata),
    .rsp_error    (rsp_error),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .waitrequest  (waitrequest),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[0]   <= 32'hA0A0_0000;
      mem[1]   <= 32'h1111_2222;
      mem[5]   <= 32'h1234_5678;
      readdata <= 32'hBAD0_BAD0;
    end else begin
      if (read && !waitrequest) readdata <= mem[address];
      else                      readdata <= 32'hBAD0_BAD0;
      if (write && !waitrequest) mem[address] <= writedata;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: each response strobe consumes one expected rsp_readdata value.
  // A strobe that arrives with nothing expected is an error.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else                   check("rsp_readdata", rsp_readdata, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  // Called in an IDLE cycle. Presents one command and services waitrequest,
  // holding it high for the first `stall` strobe cycles. It then checks the
  // strobe count, address/data stability, response cycle (counted from the
  // acceptance cycle) and response fields. It returns in the IDLE cycle that
  // follows the response.
  task automatic do_cmd(input string name, input logic wr, input logic [AW-1:0] addr,
                        input logic [W-1:0] wdata, input int stall, input bit hold,
                        input int exp_strobes, input int exp_rsp, input logic exp_err,
                        input logic [W-1:0] exp_rdata);
    int strobes = 0;
    int rsp_at  = -1;
    bit stable  = 1'b1;
    bit overlap = 1'b0;
    bit dir_ok  = 1'b1;
    bit busy_ok = 1'b1;
    check({name, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    exp_q.push_back(exp_rdata);
    cmd_valid     = 1'b1;
    cmd_write     = wr;
    cmd_address   = addr;
    cmd_writedata = wdata;
    for (int cyc = 1; cyc <= 64 && rsp_at < 0; cyc++) begin
      step();
      if (!hold) cmd_valid = 1'b0;
      if (read && write) overlap = 1'b1;
      if (cmd_ready && !rsp_valid && strobes == 0 && cyc == 1) busy_ok = 1'b0;
      if (read || write) begin
        if (address !== addr) stable = 1'b0;
        if (wr && writedata !== wdata) stable = 1'b0;
        if (write !== wr) dir_ok = 1'b0;
        waitrequest = (strobes < stall);
        strobes++;
      end else begin
        waitrequest = 1'b0;
      end
      if (rsp_valid) rsp_at = cyc;
    end
    check({name, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    check({name, "_stable"}, 32'(stable), 32'd1);
    check({name, "_dir"}, 32'(dir_ok), 32'd1);
    check({name, "_no_overlap"}, 32'(overlap), 32'd0);
    check({name, "_busy"}, 32'(busy_ok), 32'd1);
    if (rsp_at < 0) begin
      check({name, "_rsp_seen"}, 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      check({name, "_rsp_cycle"}, 32'(rsp_at), 32'(exp_rsp));
      check({name, "_rsp_write"}, 32'(rsp_write), 32'(wr));
      check({name, "_rsp_error"}, 32'(rsp_error), 32'(exp_err));
      step();
      check({name, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
      check({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit stray_rsp;
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_address   = '0;
    cmd_writedata = '0;
    waitrequest   = 1'b0;
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_readdata", rsp_readdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    step();

    // Basic write: strobe 1 cycle, response in the second cycle after acceptance.
    do_cmd("wr3", 1'b1, 4'h3, 32'hDEAD_BEEF, 0, 1'b0, 1, 2, 1'b0, 32'h0);
    // Basic read at READ_LATENCY=1: response in the third cycle.
    do_cmd("rd5", 1'b0, 4'h5, 32'h0, 0, 1'b0, 1, 3, 1'b0, 32'h1234_5678);
    // Write stalled 4 cycles: strobe 5 cycles. rsp_readdata keeps the last read.
    do_cmd("wr7_stall", 1'b1, 4'h7, 32'hCAFE_0007, 4, 1'b0, 5, 6, 1'b0, 32'h1234_5678);
    // Read back data written earlier.
    do_cmd("rd3", 1'b0, 4'h3, 32'h0, 0, 1'b0, 1, 3, 1'b0, 32'hDEAD_BEEF);
    do_cmd("rd7_stall", 1'b0, 4'h7, 32'h0, 2, 1'b0, 3, 5, 1'b0, 32'hCAFE_0007);

    // Read against a stuck waitrequest.
`ifdef AVLMM_MASTER_TIMEOUT_EN
    do_cmd("rd_stuck", 1'b0, 4'h5, 32'h0, 1000, 1'b0, 8, 9, 1'b1, 32'h0);
`else
    do_cmd("rd_stuck", 1'b0, 4'h5, 32'h0, 20, 1'b0, 21, 23, 1'b0, 32'h1234_5678);
`endif
    // A normal response after the stuck case reports no error.
    do_cmd("rd0_after", 1'b0, 4'h0, 32'h0, 0, 1'b0, 1, 3, 1'b0, 32'hA0A0_0000);

    // cmd_valid held high through two back-to-back reads.
    do_cmd("b2b_rd0", 1'b0, 4'h0, 32'h0, 0, 1'b1, 1, 3, 1'b0, 32'hA0A0_0000);
    do_cmd("b2b_rd1", 1'b0, 4'h1, 32'h0, 0, 1'b0, 1, 3, 1'b0, 32'h1111_2222);

    // Reset asserted during RDWAIT.
    check("mid_ready", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_address = 4'h5;
    step();
    cmd_valid = 1'b0;
    check("mid_read_issued", 32'(read), 32'd1);
    step();
    check("mid_in_rdwait", 32'(state_dbg), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_read", 32'(read), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_readdata", rsp_readdata, 32'd0);
    check("mid_rst_address", 32'(address), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    step();
    rst = 1'b0;
    stray_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid) stray_rsp = 1'b1;
    end
    check("mid_no_rsp", 32'(stray_rsp), 32'd0);
    do_cmd("rd5_post_rst", 1'b0, 4'h5, 32'h0, 0, 1'b0, 1, 3, 1'b0, 32'h1234_5678);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
